// File: rtl/retire_stage_pkg.sv
// Shared ROB head packet, retire FSM states and helpers for the retire stage.
package retire_stage_pkg;

    localparam int SYS_PHYS_REG_WIDTH = 6;
    localparam int SYS_XLEN           = 32;

    typedef struct packed {
        logic                          valid;
        logic                          completed;
        logic                          precise_state_need;
        logic [SYS_XLEN-1:0]           cs_retire_pc;
        logic [SYS_PHYS_REG_WIDTH-1:0] Told;
        logic [SYS_PHYS_REG_WIDTH-1:0] Tnew;
        logic [4:0]                    arch_dest;
        logic                          is_store;
        logic                          halt;
    } ROB_ENTRY_PACKET;

    typedef enum logic [1:0] {
        RS_RUN,
        RS_RECOVER,
        RS_DRAIN,
        RS_HALTED
    } retire_state_e;

    typedef enum logic [1:0] {
        STOP_NONE,
        STOP_REC,
        STOP_HALT
    } stop_cause_e;

    function automatic logic [1:0] popcount3(input logic [2:0] m);
        return 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
    endfunction

endpackage

// File: rtl/retire_stage_select.sv
// Combinational retire eligibility: contiguous prefix, one store per cycle.
module retire_select
    import retire_stage_pkg::*;
(
    input  ROB_ENTRY_PACKET [2:0] head_i,
    input  logic                  sq_ready_i,
    input  retire_state_e         state_i,
    output logic [2:0]            mask_o,
    output stop_cause_e           cause_o,
    output logic [1:0]            idx_o
);

    logic blocked;
    logic store_taken;

    always_comb begin
        mask_o      = '0;
        cause_o     = STOP_NONE;
        idx_o       = '0;
        blocked     = (state_i != RS_RUN);
        store_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!blocked) begin
                if (head_i[i].valid && head_i[i].completed &&
                    (!head_i[i].is_store || (sq_ready_i && !store_taken))) begin
                    mask_o[i]   = 1'b1;
                    store_taken = store_taken | head_i[i].is_store;
                    // The stopping entry itself retires; only younger slots are held.
                    if (head_i[i].halt) begin
                        blocked = 1'b1;
                        cause_o = STOP_HALT;
                        idx_o   = 2'(i);
                    end else if (head_i[i].precise_state_need) begin
                        blocked = 1'b1;
                        cause_o = STOP_REC;
                        idx_o   = 2'(i);
                    end
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/retire_stage.sv
// Three-wide in-order retire: commit, freelist return, recovery and halt FSM.
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  ROB_ENTRY_PACKET [2:0]                rob_head_pkts,
    input  logic                                 sq_retire_ready,
    output logic [2:0]                           retire_mask,
    output logic [2:0]                           fl_free_valid,
    output logic [2:0][SYS_PHYS_REG_WIDTH-1:0]   fl_free_preg,
    output logic [2:0]                           amt_we,
    output logic [2:0][4:0]                      amt_areg,
    output logic [2:0][SYS_PHYS_REG_WIDTH-1:0]   amt_preg,
    output logic                                 sq_retire_valid,
    output logic                                 rec_valid,
    output logic [SYS_XLEN-1:0]                  rec_pc,
    output logic                                 halted,
    output logic [63:0]                          retired_count
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    retire_state_e                         state_q;
    logic [CNT_W-1:0]                      cnt_q;
    logic [2:0]                            fl_free_valid_q;
    logic [2:0][SYS_PHYS_REG_WIDTH-1:0]    fl_free_preg_q;
    logic [2:0]                            amt_we_q;
    logic [2:0][4:0]                       amt_areg_q;
    logic [2:0][SYS_PHYS_REG_WIDTH-1:0]    amt_preg_q;
    logic                                  sq_retire_valid_q;
    logic                                  rec_valid_q;
    logic [SYS_XLEN-1:0]                   rec_pc_q;
    logic                                  halted_q;
    logic [63:0]                           retired_count_q;

    logic [2:0]  sel_mask;
    stop_cause_e stop_cause;
    logic [1:0]  stop_idx;
    logic [2:0]  store_vec;

    retire_select u_select (
        .head_i     (rob_head_pkts),
        .sq_ready_i (sq_retire_ready),
        .state_i    (state_q),
        .mask_o     (sel_mask),
        .cause_o    (stop_cause),
        .idx_o      (stop_idx)
    );

    assign retire_mask = rst ? sel_mask : 3'b000;

    always_comb begin
        store_vec = '0;
        for (int i = 0; i < 3; i++) begin
            store_vec[i] = rob_head_pkts[i].is_store;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= RS_RUN;
            cnt_q             <= '0;
            fl_free_valid_q   <= '0;
            fl_free_preg_q    <= '0;
            amt_we_q          <= '0;
            amt_areg_q        <= '0;
            amt_preg_q        <= '0;
            sq_retire_valid_q <= 1'b0;
            rec_valid_q       <= 1'b0;
            rec_pc_q          <= '0;
            halted_q          <= 1'b0;
            retired_count_q   <= '0;
        end else begin
            retired_count_q   <= retired_count_q + 64'(popcount3(retire_mask));
            sq_retire_valid_q <= |(retire_mask & store_vec);
            rec_valid_q       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                // Physical register 0 is the hardwired zero and never returns to the freelist.
                fl_free_valid_q[i] <= retire_mask[i] &&
                                      (rob_head_pkts[i].arch_dest != 5'd0) &&
                                      (rob_head_pkts[i].Told != '0);
                fl_free_preg_q[i]  <= rob_head_pkts[i].Told;
                amt_we_q[i]        <= retire_mask[i] &&
                                      (rob_head_pkts[i].arch_dest != 5'd0);
                amt_areg_q[i]      <= rob_head_pkts[i].arch_dest;
                amt_preg_q[i]      <= rob_head_pkts[i].Tnew;
            end
            unique case (state_q)
                RS_RUN: begin
                    if (stop_cause == STOP_REC) begin
                        state_q     <= RS_RECOVER;
                        rec_valid_q <= 1'b1;
                        rec_pc_q    <= rob_head_pkts[stop_idx].cs_retire_pc;
                    end else if (stop_cause == STOP_HALT) begin
                        state_q  <= RS_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                RS_RECOVER: begin
                    state_q <= RS_DRAIN;
                    cnt_q   <= CNT_W'(DRAIN_CYCLES);
                end
                RS_DRAIN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= RS_RUN;
                    end
                end
                RS_HALTED: begin
                    state_q <= RS_HALTED;
                end
            endcase
        end
    end

    assign fl_free_valid   = fl_free_valid_q;
    assign fl_free_preg    = fl_free_preg_q;
    assign amt_we          = amt_we_q;
    assign amt_areg        = amt_areg_q;
    assign amt_preg        = amt_preg_q;
    assign sq_retire_valid = sq_retire_valid_q;
    assign rec_valid       = rec_valid_q;
    assign rec_pc          = rec_pc_q;
    assign halted          = halted_q;
    assign retired_count   = retired_count_q;

endmodule

// File: tb/tb_retire_stage.sv
// Directed-vector bench for retire_stage with hand-computed expectations.
module tb_retire_stage;
    import retire_stage_pkg::*;

    logic                                clk;
    logic                                rst;
    ROB_ENTRY_PACKET [2:0]               rob_head_pkts;
    logic                                sq_retire_ready;
    logic [2:0]                          retire_mask;
    logic [2:0]                          fl_free_valid;
    logic [2:0][SYS_PHYS_REG_WIDTH-1:0]  fl_free_preg;
    logic [2:0]                          amt_we;
    logic [2:0][4:0]                     amt_areg;
    logic [2:0][SYS_PHYS_REG_WIDTH-1:0]  amt_preg;
    logic                                sq_retire_valid;
    logic                                rec_valid;
    logic [SYS_XLEN-1:0]                 rec_pc;
    logic                                halted;
    logic [63:0]                         retired_count;

    int n_vec;
    int n_err;

    retire_stage #(.DRAIN_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .rob_head_pkts   (rob_head_pkts),
        .sq_retire_ready (sq_retire_ready),
        .retire_mask     (retire_mask),
        .fl_free_valid   (fl_free_valid),
        .fl_free_preg    (fl_free_preg),
        .amt_we          (amt_we),
        .amt_areg        (amt_areg),
        .amt_preg        (amt_preg),
        .sq_retire_valid (sq_retire_valid),
        .rec_valid       (rec_valid),
        .rec_pc          (rec_pc),
        .halted          (halted),
        .retired_count   (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ROB_ENTRY_PACKET mk(
        input logic v, input logic c, input logic psn, input logic [31:0] pc,
        input logic [5:0] told, input logic [5:0] tnew, input logic [4:0] ad,
        input logic st, input logic h);
        ROB_ENTRY_PACKET e;
        e.valid              = v;
        e.completed          = c;
        e.precise_state_need = psn;
        e.cs_retire_pc       = pc;
        e.Told               = told;
        e.Tnew               = tnew;
        e.arch_dest          = ad;
        e.is_store           = st;
        e.halt               = h;
        return e;
    endfunction

    function automatic ROB_ENTRY_PACKET alu(input logic [5:0] told, input logic [5:0] tnew,
                                            input logic [4:0] ad);
        return mk(1'b1, 1'b1, 1'b0, 32'h0, told, tnew, ad, 1'b0, 1'b0);
    endfunction

    function automatic ROB_ENTRY_PACKET inv();
        return mk(1'b0, 1'b0, 1'b0, 32'h0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b0);
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        sq_retire_ready = 1'b1;
        rob_head_pkts = {alu(6'd1, 6'd2, 5'd1), alu(6'd3, 6'd4, 5'd2), alu(6'd5, 6'd6, 5'd3)};
        #2;
        chk("rst_mask", 64'(retire_mask), 64'h0);
        chk("rst_flv", 64'(fl_free_valid), 64'h0);
        chk("rst_amt_we", 64'(amt_we), 64'h0);
        chk("rst_count", retired_count, 64'h0);
        chk("rst_rec", 64'(rec_valid), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        rob_head_pkts = {inv(), inv(), inv()};
        #5 rst = 1'b1;

        tick();
        chk("empty_mask", 64'(retire_mask), 64'h0);

        rob_head_pkts = {alu(6'd2, 6'd12, 5'd3), alu(6'd1, 6'd11, 5'd2), alu(6'd0, 6'd10, 5'd1)};
        #1 chk("alu3_mask", 64'(retire_mask), 64'b111);
        tick();
        chk("alu3_flv", 64'(fl_free_valid), 64'b110);
        chk("alu3_amt_we", 64'(amt_we), 64'b111);
        chk("alu3_count", retired_count, 64'd3);
        chk("alu3_areg", 64'(amt_areg), 64'({5'd3, 5'd2, 5'd1}));
        chk("alu3_preg", 64'(amt_preg), 64'({6'd12, 6'd11, 6'd10}));
        chk("alu3_fpreg", 64'(fl_free_preg), 64'({6'd2, 6'd1, 6'd0}));

        rob_head_pkts = {alu(6'd9, 6'd15, 5'd5), alu(6'd8, 6'd14, 5'd0), alu(6'd7, 6'd13, 5'd4)};
        #1 chk("x0_mask", 64'(retire_mask), 64'b111);
        tick();
        chk("x0_flv", 64'(fl_free_valid), 64'b101);
        chk("x0_amt_we", 64'(amt_we), 64'b101);
        chk("x0_count", retired_count, 64'd6);

        rob_head_pkts = {alu(6'd3, 6'd4, 5'd3),
                         mk(1'b1, 1'b0, 1'b0, 32'h0, 6'd2, 6'd5, 5'd2, 1'b0, 1'b0),
                         alu(6'd1, 6'd6, 5'd1)};
        #1 chk("gap_mask", 64'(retire_mask), 64'b001);
        tick();
        chk("gap_count", retired_count, 64'd7);

        rob_head_pkts = {alu(6'd3, 6'd4, 5'd3), alu(6'd2, 6'd5, 5'd2), inv()};
        #1 chk("inv0_mask", 64'(retire_mask), 64'b000);

        rob_head_pkts = {inv(),
                         mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0),
                         mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0)};
        #1 chk("st2_mask", 64'(retire_mask), 64'b001);
        tick();
        chk("st2_sqv", 64'(sq_retire_valid), 64'h1);
        rob_head_pkts = {inv(), inv(), mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 6'd0, 5'd0, 1'b1, 1'b0)};
        #1 chk("st1_mask", 64'(retire_mask), 64'b001);
        sq_retire_ready = 1'b0;
        #1 chk("st_nrdy_mask", 64'(retire_mask), 64'b000);
        tick();
        chk("st_nrdy_sqv", 64'(sq_retire_valid), 64'h0);
        chk("st_count", retired_count, 64'd8);
        sq_retire_ready = 1'b1;

        rob_head_pkts = {inv(), alu(6'd4, 6'd8, 5'd6),
                         mk(1'b1, 1'b1, 1'b1, 32'h5000, 6'd3, 6'd9, 5'd7, 1'b0, 1'b0)};
        #1 chk("psn_mask", 64'(retire_mask), 64'b001);
        tick();
        chk("psn_rec", 64'(rec_valid), 64'h1);
        chk("psn_pc", 64'(rec_pc), 64'h5000);
        rob_head_pkts = {inv(), inv(), alu(6'd4, 6'd8, 5'd6)};
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("drain_mask%0d", k), 64'(retire_mask), 64'b000);
            tick();
            if (k == 0) chk("drain_rec_off", 64'(rec_valid), 64'h0);
        end
        chk("drain_count", retired_count, 64'd9);
        chk("run_mask", 64'(retire_mask), 64'b001);
        tick();
        chk("run_count", retired_count, 64'd10);

        rob_head_pkts = {inv(), mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1),
                         mk(1'b1, 1'b1, 1'b1, 32'h6000, 6'd3, 6'd9, 5'd7, 1'b0, 1'b0)};
        #1 chk("psnhalt_mask", 64'(retire_mask), 64'b001);
        tick();
        chk("psnhalt_pc", 64'(rec_pc), 64'h6000);
        chk("psnhalt_halted", 64'(halted), 64'h0);
        rob_head_pkts = {inv(), inv(), alu(6'd4, 6'd8, 5'd6)};
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_count", retired_count, 64'h0);
        chk("arst_amt_we", 64'(amt_we), 64'h0);
        chk("arst_mask", 64'(retire_mask), 64'h0);
        chk("arst_rec", 64'(rec_valid), 64'h0);
        rst = 1'b1;
        #1 chk("rel_mask", 64'(retire_mask), 64'b001);
        tick();
        chk("rel_count", retired_count, 64'd1);
        chk("rel_rec", 64'(rec_valid), 64'h0);

        rob_head_pkts = {alu(6'd5, 6'd6, 5'd8),
                         mk(1'b1, 1'b1, 1'b0, 32'h0, 6'd0, 6'd0, 5'd0, 1'b0, 1'b1),
                         alu(6'd4, 6'd7, 5'd9)};
        #1 chk("halt_mask", 64'(retire_mask), 64'b011);
        tick();
        chk("halt_set", 64'(halted), 64'h1);
        chk("halt_count", retired_count, 64'd3);
        rob_head_pkts = {alu(6'd5, 6'd6, 5'd8), alu(6'd6, 6'd7, 5'd9), alu(6'd7, 6'd8, 5'd10)};
        for (int k = 0; k < 2; k++) begin
            #1 chk($sformatf("halted_mask%0d", k), 64'(retire_mask), 64'b000);
            tick();
            chk($sformatf("halted_sticky%0d", k), 64'(halted), 64'h1);
        end
        chk("halted_count", retired_count, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 2: cycles retirement stays blocked after a recovery pulse.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rob_head_pkts  input  ROB_ENTRY_PACKET[2:0]  three oldest ROB entries; [0] is oldest.
REQ-005 SHALL have port sq_retire_ready  input  1  store queue can commit one store this cycle.
REQ-006 SHALL have port retire_mask  output  3  combinational; slots popped from the ROB at this edge.
REQ-007 SHALL have port fl_free_valid  output  3  registered; Told[i] returned to the freelist.
REQ-008 SHALL have port fl_free_preg  output  [2:0][`SYS_PHYS_REG_WIDTH-1:0]  registered Told per slot.
REQ-009 SHALL have port amt_we  output  3  registered architectural map table write enables.
REQ-010 SHALL have port amt_areg  output  [2:0][4:0]  registered arch_dest per slot.
REQ-011 SHALL have port amt_preg  output  [2:0][`SYS_PHYS_REG_WIDTH-1:0]  registered Tnew per slot.
REQ-012 SHALL have port sq_retire_valid  output  1  registered; one store committed.
REQ-013 SHALL have port rec_valid  output  1  registered one-cycle recovery pulse to fetch and all queues.
REQ-014 SHALL have port rec_pc  output  `SYS_XLEN  registered redirect PC, valid with rec_valid.
REQ-015 SHALL have port halted  output  1  sticky; halt instruction retired.
REQ-016 SHALL have port retired_count  output  64  committed-instruction counter.

Function
REQ-017 Slot i SHALL retire iff valid and completed, all older slots retire, no older retiring slot has precise_state_need or halt, and the FSM is in RUN.
REQ-018 A store slot SHALL retire only if sq_retire_ready is 1 and no older slot retires a store this cycle (max one store per cycle).
REQ-019 retire_mask SHALL be a contiguous prefix from slot 0 (legal values 000, 001, 011, 111).
REQ-020 fl_free_valid[i] and amt_we[i] SHALL be set one cycle after retire_mask[i], suppressed when arch_dest is 0.
REQ-021 When arch_dest values collide among slots retiring in the same cycle, all amt_we SHALL still assert; the consumer applies the youngest (highest index) write.
REQ-022 retired_count SHALL increase by popcount(retire_mask) each cycle and wrap modulo 2^64.
REQ-023 FSM states SHALL be RUN, RECOVER, DRAIN and HALTED.
REQ-024 In RUN, retiring an entry with precise_state_need SHALL mask all younger slots, latch that entry's cs_retire_pc, and go to RECOVER.
REQ-025 In RECOVER, the block SHALL assert rec_valid and rec_pc for exactly one cycle, hold retire_mask at 0, load the drain counter with DRAIN_CYCLES, and go to DRAIN.
REQ-026 In DRAIN, the counter SHALL decrement each cycle with retire_mask at 0, returning to RUN in the cycle after the counter reaches 1.
REQ-027 In RUN, retiring an entry with halt SHALL mask younger slots, set halted the next cycle, and enter HALTED; HALTED SHALL be exited only by reset and SHALL keep retire_mask at 0.
REQ-028 If a halt and a precise_state_need entry are both eligible, only the older of the two SHALL retire.
REQ-029 Invalid head slots SHALL never retire; an empty ROB SHALL give retire_mask 000.

Reset
REQ-030 While rst is 0, the FSM SHALL be in RUN, all registered outputs and retired_count SHALL be 0, and retire_mask SHALL be 0.
REQ-031 Reset asserted mid-RECOVER or mid-DRAIN SHALL abort immediately with no rec_valid pulse.

Structure
REQ-032 ROB_ENTRY_PACKET in sys_defs.svh SHALL gain the fields arch_dest[4:0], is_store and halt; the retire FSM state enum SHALL live there too.
REQ-033 Slot eligibility SHALL be a combinational sub-module retire_select (head packets, sq_retire_ready, state in; mask, stop cause and stop index out).

Verification
REQ-034 Three completed ALU entries (Told 0/1/2, arch_dest 1/2/3) -> retire_mask 111; next cycle fl_free_valid=110, amt_we=111, retired_count=3.
REQ-035 Slots 0 and 2 completed, slot 1 not -> retire_mask 001.
REQ-036 Two completed stores in slots 0 and 1 with sq_retire_ready=1 -> mask 001 then 001 on the following cycle; sq_retire_ready=0 -> mask 000.
REQ-037 Slot 0 has precise_state_need with cs_retire_pc 0x5000 and slot 1 is completed -> mask 001; next cycle rec_valid=1 and rec_pc=0x5000 for one cycle; mask 0 for 1+DRAIN_CYCLES cycles, then RUN.
REQ-038 Slot 1 halt, slot 2 completed -> mask 011; halted=1 the next cycle and stays set; mask 0 thereafter even with new completed heads.
REQ-039 rst driven low during DRAIN -> all outputs 0 asynchronously; after release, a completed head retires on the first edge.
